// File: rtl/traffic_pkg.sv
// Shared encodings and defaults for the traffic light controller and its
// input conditioners (vehicle detector today, highway/pedestrian later).
package traffic_pkg;

  // Light encodings driven by the controller.
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_t;

  // Vehicle detector FSM states.
  typedef enum logic [2:0] {
    VD_IDLE     = 3'd0,
    VD_QUAL_ON  = 3'd1,
    VD_PRESENT  = 3'd2,
    VD_QUAL_OFF = 3'd3,
    VD_FAULT    = 3'd4
  } vd_state_t;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_HOLD_CYCLES  = 8;
  localparam int DEF_STUCK_CYCLES = 1024;
  localparam int DEF_CNT_W        = 8;

  // Bits needed to hold every value 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep meta and q as two distinct stages;
    // blocking ones would let d reach q in a single clock.
    if (clear) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vehicle_detect.sv
// Country-road loop detector conditioner: synchronizes and debounces the raw
// sensor, stretches gaps with a hold timer, counts arrivals since the last
// country green and fails safe (x held high) when the sensor sticks high.
module vehicle_detect
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             raw_sense,
  input  logic             cntry_green,
  output logic             x,
  output logic             arrival,
  output logic [CNT_W-1:0] car_count,
  output logic             sensor_fault
);

  localparam int DEB_W   = cnt_width(DEB_CYCLES - 1);
  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int STUCK_W = cnt_width(STUCK_CYCLES - 1);

  localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  logic                s;
  vd_state_t           state, state_nxt;
  logic [DEB_W-1:0]    deb_cnt, deb_cnt_nxt;
  logic [STUCK_W-1:0]  stuck_cnt, stuck_cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                hold_load;
  logic                qual_arrival;
  logic                green_q;
  logic                green_rise;

  sync_2ff u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (raw_sense),
    .q     (s)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= VD_IDLE;
      deb_cnt   <= '0;
      stuck_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_cnt_nxt;
      stuck_cnt <= stuck_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // Next-state logic: debounce on/off, stuck-high watchdog, fault recovery.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_nxt     = state;
    deb_cnt_nxt   = deb_cnt;
    stuck_cnt_nxt = stuck_cnt;
    hold_load     = 1'b0;
    qual_arrival  = 1'b0;

    unique case (state)
      VD_IDLE: begin
        if (s) begin
          state_nxt   = VD_QUAL_ON;
          deb_cnt_nxt = DEB_ONE;
        end
      end

      VD_QUAL_ON: begin
        if (!s) begin
          state_nxt   = VD_IDLE;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt     = VD_PRESENT;
          deb_cnt_nxt   = '0;
          stuck_cnt_nxt = '0;
          qual_arrival  = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_ONE;
        end
      end

      VD_PRESENT: begin
        if (stuck_cnt == STUCK_LAST) begin
          state_nxt   = VD_FAULT;
          deb_cnt_nxt = '0;
        end else begin
          stuck_cnt_nxt = stuck_cnt + STUCK_W'(1);
          if (!s) begin
            state_nxt   = VD_QUAL_OFF;
            deb_cnt_nxt = DEB_ONE;
          end
        end
      end

      VD_QUAL_OFF: begin
        // The watchdog keeps running through short dropouts.
        if (stuck_cnt != STUCK_LAST) stuck_cnt_nxt = stuck_cnt + STUCK_W'(1);
        if (s) begin
          state_nxt   = VD_PRESENT;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = VD_IDLE;
          deb_cnt_nxt = '0;
          hold_load   = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_ONE;
        end
      end

      VD_FAULT: begin
        // Recover only after a full debounce window of clean lows.
        if (s) begin
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = VD_IDLE;
          deb_cnt_nxt = '0;
          hold_load   = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_ONE;
        end
      end

      default: begin
        state_nxt   = VD_IDLE;
        deb_cnt_nxt = '0;
      end
    endcase

    // Gap-extension timer: load wins, a new arrival cancels, else count down.
    if (hold_load)            hold_cnt_nxt = HOLD_LOAD;
    else if (qual_arrival)    hold_cnt_nxt = '0;
    else if (hold_cnt != '0)  hold_cnt_nxt = hold_cnt - HOLD_W'(1);
    else                      hold_cnt_nxt = hold_cnt;
  end

  assign green_rise = cntry_green & ~green_q;

  // Arrival pulse and saturating arrival counter, cleared by a country green rise.
  always_ff @(posedge clk) begin
    if (clear) begin
      arrival   <= 1'b0;
      green_q   <= 1'b0;
      car_count <= '0;
    end else begin
      arrival <= qual_arrival;
      green_q <= cntry_green;
      if (green_rise)
        car_count <= qual_arrival ? CNT_W'(1) : '0;
      else if (qual_arrival && car_count != CNT_MAX)
        car_count <= car_count + CNT_W'(1);
    end
  end

  assign x = (state == VD_PRESENT) || (state == VD_QUAL_OFF) ||
             (state == VD_FAULT)   || (hold_cnt != '0);
  assign sensor_fault = (state == VD_FAULT);

endmodule

// File: tb/tb_vehicle_detect.sv
// Directed bench for vehicle_detect (DEB=4, HOLD=8, STUCK=32, CNT_W=8).
// Each tick is one rising edge; inputs change and outputs are sampled 1 time
// unit after that edge.
module tb_vehicle_detect;
  import traffic_pkg::*;

  logic       clk;
  logic       clear;
  logic       raw_sense;
  logic       cntry_green;
  logic       x;
  logic       arrival;
  logic [7:0] car_count;
  logic       sensor_fault;

  int tests_run    = 0;
  int tests_failed = 0;
  int arr_seen     = 0;

  vehicle_detect #(
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (8),
    .STUCK_CYCLES (32),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .raw_sense    (raw_sense),
    .cntry_green  (cntry_green),
    .x            (x),
    .arrival      (arrival),
    .car_count    (car_count),
    .sensor_fault (sensor_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (arrival === 1'b1) arr_seen++;
  endtask

  // Minimal qualified vehicle: 4 high samples, then 6 low ticks; ends on the
  // tick where the FSM re-enters IDLE with the hold timer loaded.
  task automatic vehicle4();
    raw_sense = 1'b1;
    repeat (4) tick();
    raw_sense = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear       = 1'b1;
    raw_sense   = 1'b0;
    cntry_green = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_x", x, 0);
    check("rst_arrival", arrival, 0);
    check("rst_count", car_count, 0);
    check("rst_fault", sensor_fault, 0);
    check("rst_state", dut.state, VD_IDLE);
    check("rst_hold", dut.hold_cnt, 0);
    check("rst_stuck", dut.stuck_cnt, 0);

    // Glitch: two high samples reach QUAL_ON, never PRESENT
    clear     = 1'b0;
    raw_sense = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) raw_sense = 1'b0;
      check("glitch_x", x, 0);
      check("glitch_arrival", arrival, 0);
      check("glitch_count", car_count, 0);
      if (k == 3) begin
        check("glitch_state3", dut.state, VD_QUAL_ON);
        check("glitch_deb3", dut.deb_cnt, 1);
      end
      if (k == 4) check("glitch_deb4", dut.deb_cnt, 2);
      if (k == 5) check("glitch_state5", dut.state, VD_IDLE);
    end

    // Clean vehicle: 20 high ticks, then release
    raw_sense = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 20) raw_sense = 1'b0;
      check("clean_x", x, (k >= 6 && k <= 33) ? 1 : 0);
      check("clean_arrival", arrival, (k == 6) ? 1 : 0);
      if (k == 5) begin
        check("clean_state5", dut.state, VD_QUAL_ON);
        check("clean_deb5", dut.deb_cnt, 3);
      end
      if (k == 6) begin
        check("clean_state6", dut.state, VD_PRESENT);
        check("clean_count6", car_count, 1);
        check("clean_stuck6", dut.stuck_cnt, 0);
      end
      if (k == 20) check("clean_stuck20", dut.stuck_cnt, 14);
      if (k == 23) begin
        check("clean_state23", dut.state, VD_QUAL_OFF);
        check("clean_deb23", dut.deb_cnt, 1);
      end
      if (k == 25) check("clean_state25", dut.state, VD_QUAL_OFF);
      if (k == 26) begin
        check("clean_state26", dut.state, VD_IDLE);
        check("clean_hold26", dut.hold_cnt, 8);
      end
      if (k == 30) check("clean_hold30", dut.hold_cnt, 4);
      if (k == 34) check("clean_hold34", dut.hold_cnt, 0);
    end
    check("clean_count_end", car_count, 1);

    // Country green rise clears the count on the following cycle
    cntry_green = 1'b1;
    tick();
    check("green_clear1", car_count, 0);
    cntry_green = 1'b0;
    tick();

    // Bounce: 3-tick dip while PRESENT is absorbed by QUAL_OFF
    raw_sense = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8)  raw_sense = 1'b0;
      if (k == 11) raw_sense = 1'b1;
      if (k >= 6) check("bounce_x", x, 1);
      check("bounce_arrival", arrival, (k == 6) ? 1 : 0);
      if (k == 11) check("bounce_state11", dut.state, VD_QUAL_OFF);
      if (k == 13) begin
        check("bounce_state13", dut.state, VD_QUAL_OFF);
        check("bounce_deb13", dut.deb_cnt, 3);
      end
      if (k == 14) check("bounce_state14", dut.state, VD_PRESENT);
    end
    check("bounce_count", car_count, 1);
    raw_sense = 1'b0;
    repeat (16) tick();
    check("bounce_end_x", x, 0);
    check("bounce_end_state", dut.state, VD_IDLE);

    // Saturation: 260 vehicles from a count of 1
    arr_seen = 0;
    for (int i = 0; i < 260; i++) begin
      vehicle4();
      if (i == 253) check("sat_count_254", car_count, 255);
    end
    repeat (10) tick();
    check("sat_count_end", car_count, 255);
    check("sat_arrivals", arr_seen, 260);

    // Green rise from a saturated count
    cntry_green = 1'b1;
    tick();
    check("green_clear2", car_count, 0);
    cntry_green = 1'b0;
    tick();

    // Arrival and green rise on the same edge -> 1
    raw_sense = 1'b1;
    repeat (4) tick();
    raw_sense = 1'b0;
    tick();
    check("same_pre_count", car_count, 0);
    cntry_green = 1'b1;
    tick();
    check("same_arrival", arrival, 1);
    check("same_count", car_count, 1);
    repeat (4) tick();
    // Green held high does not clear again
    vehicle4();
    check("green_held_count", car_count, 2);
    cntry_green = 1'b0;
    repeat (12) tick();
    check("pre_stuck_x", x, 0);

    // Stuck-high sensor, then release
    raw_sense = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 45) raw_sense = 1'b0;
      if (k >= 6 && k <= 58) check("stuck_x", x, 1);
      if (k == 37) begin
        check("stuck_state37", dut.state, VD_PRESENT);
        check("stuck_cnt37", dut.stuck_cnt, 31);
        check("stuck_fault37", sensor_fault, 0);
      end
      if (k == 38) begin
        check("stuck_state38", dut.state, VD_FAULT);
        check("stuck_fault38", sensor_fault, 1);
        check("stuck_count38", car_count, 3);
      end
      if (k == 45) check("stuck_state45", dut.state, VD_FAULT);
      if (k == 50) begin
        check("stuck_state50", dut.state, VD_FAULT);
        check("stuck_deb50", dut.deb_cnt, 3);
        check("stuck_fault50", sensor_fault, 1);
      end
      if (k == 51) begin
        check("stuck_state51", dut.state, VD_IDLE);
        check("stuck_fault51", sensor_fault, 0);
        check("stuck_hold51", dut.hold_cnt, 8);
      end
      if (k == 58) check("stuck_hold58", dut.hold_cnt, 1);
      if (k == 59) check("stuck_x59", x, 0);
    end

    // Clear asserted mid-hold
    vehicle4();
    repeat (3) tick();
    check("midhold_hold", dut.hold_cnt, 5);
    check("midhold_x", x, 1);
    check("midhold_count", car_count, 4);
    clear = 1'b1;
    tick();
    check("midclr_x", x, 0);
    check("midclr_state", dut.state, VD_IDLE);
    check("midclr_hold", dut.hold_cnt, 0);
    check("midclr_count", car_count, 0);
    clear = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
